// File: rtl/deser_serpar_n.sv
// deser_serpar_n - N-channel serial-to-parallel deserialiser on the 160 MHz bit clock.
//
// Every channel shifts in one bit per clk160 edge (MSB = earliest bit). A shared
// word counter captures all channels together once per WIDTH cycles. One cycle
// later a write strobe is issued unless the idle-suppression rule applies.
// An align request searches channel 0 for SYNC_PATTERN and re-phases the word
// counter on a match. Locked and sticky timeout status are reported.
//
// Ports:
//   clk160       in   bit clock
//   reset        in   asynchronous, active-high
//   run          in   enables capture and write
//   align        in   single-cycle request to (re)start the frame search
//   idle_mode    in   0: suppress if any channel idle, 1: only if all idle, 2/3: never
//   ser          in   serial inputs, bit i = channel i
//   par          out  parallel words, channel i at [i*WIDTH +: WIDTH]
//   write        out  one-cycle strobe, par valid
//   locked       out  frame alignment achieved
//   timeout_err  out  sticky, search expired without a match
//   test         out  {fsm_state[1:0], match, capture}
module deser_serpar_n #(
  parameter int              NCH          = 2,
  parameter int              WIDTH        = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD    = '1,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(16'hBC50),
  parameter int              TIMEOUT      = 1024
) (
  input  logic                 clk160,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 align,
  input  logic [1:0]           idle_mode,
  input  logic [NCH-1:0]       ser,
  output logic [NCH*WIDTH-1:0] par,
  output logic                 write,
  output logic                 locked,
  output logic                 timeout_err,
  output logic [3:0]           test
);

  localparam int CW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Decides whether a freshly captured set of words is withheld from the FIFO.
  function automatic logic idle_suppress(input logic [NCH*WIDTH-1:0] words,
                                         input logic [1:0]           mode);
    logic any_idle;
    logic all_idle;
    any_idle = 1'b0;
    all_idle = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (words[i*WIDTH +: WIDTH] == IDLE_WORD) any_idle = 1'b1;
      else                                      all_idle = 1'b0;
    end
    case (mode)
      2'd0:    return any_idle;
      2'd1:    return all_idle;
      default: return 1'b0;
    endcase
  endfunction

  logic [NCH*WIDTH-1:0] shift_p0;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tmo, tmo_n;
  state_t               state, state_n;
  logic                 locked_n, timeout_err_n;
  logic                 resync;
  logic                 match;
  logic                 capture;
  logic                 vld_p1;

  assign match   = (shift_p0[WIDTH-1:0] == SYNC_PATTERN);
  assign capture = run && (cnt == CNT_LAST) && (state != SEARCH);
  assign test    = {state, match, capture};

  // Alignment FSM: next state and status.
  always_comb begin
    state_n       = state;
    tmo_n         = tmo;
    locked_n      = locked;
    timeout_err_n = timeout_err;
    resync        = 1'b0;
    case (state)
      UNLOCKED: begin
        if (align) begin
          state_n       = SEARCH;
          tmo_n         = '0;
          locked_n      = 1'b0;
          timeout_err_n = 1'b0;
        end
      end
      SEARCH: begin
        // A match outranks a repeated align request.
        if (match) begin
          resync   = 1'b1;
          locked_n = 1'b1;
          state_n  = LOCKED;
        end else if (align) begin
          tmo_n = '0;
        end else if (tmo == TMO_LAST) begin
          timeout_err_n = 1'b1;
          state_n       = UNLOCKED;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      LOCKED: begin
        if (align) begin
          state_n       = SEARCH;
          tmo_n         = '0;
          locked_n      = 1'b0;
          timeout_err_n = 1'b0;
        end
      end
      default: state_n = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      state       <= UNLOCKED;
      tmo         <= '0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      tmo         <= tmo_n;
      locked      <= locked_n;
      timeout_err <= timeout_err_n;
      // On a sync match the word boundary is moved to just after the pattern.
      if (resync || cnt == CNT_LAST) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
    end
  end

  // Stage 0: per-channel shift registers, running independently of run.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      shift_p0 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shift_p0[i*WIDTH +: WIDTH] <= {shift_p0[i*WIDTH +: WIDTH-1], ser[i]};
      end
    end
  end

  // Stage 1: parallel capture of all channels.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      par    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (capture) par <= shift_p0;
    end
  end

  // Stage 2: write strobe, judged on the words now held in par.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) write <= 1'b0;
    else       write <= vld_p1 && !idle_suppress(par, idle_mode);
  end

endmodule

// File: tb/tb_deser_serpar_n.sv
// Randomised scoreboard bench for deser_serpar_n (NCH=2, WIDTH=16, TIMEOUT=64).
// A reference model, stepped once per clock by the stimulus process, queues the
// expected capture/write results and status; a monitor compares them on negedges.
module tb_deser_serpar_n;

  localparam int          NCH  = 2;
  localparam int          W    = 16;
  localparam int          TMO  = 64;
  localparam logic [15:0] SYNC = 16'hBC50;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic        clk160 = 1'b0;
  logic        reset  = 1'b1;
  logic        run    = 1'b0;
  logic        align  = 1'b0;
  logic [1:0]  idle_mode = 2'd0;
  logic [1:0]  ser    = 2'b00;
  logic [31:0] par;
  logic        write;
  logic        locked;
  logic        timeout_err;
  logic [3:0]  test;

  deser_serpar_n #(
    .NCH(NCH), .WIDTH(W), .IDLE_WORD(IDLE), .SYNC_PATTERN(SYNC), .TIMEOUT(TMO)
  ) dut (
    .clk160(clk160), .reset(reset), .run(run), .align(align),
    .idle_mode(idle_mode), .ser(ser), .par(par), .write(write),
    .locked(locked), .timeout_err(timeout_err), .test(test)
  );

  always #3 clk160 = ~clk160;

  int ecnt = 0;
  always @(posedge clk160) ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int stamp; logic [31:0] par; logic wr; } cap_t;
  typedef struct { int stamp; logic lock; logic terr; logic match; } stat_t;
  cap_t  cq[$];
  stat_t sq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int S_FREE = 0, S_SEARCH = 1, S_LOCK = 2;
  int          m_mode;
  int          m_pos;      // bit position of the next sample inside the current word
  int          m_tmo;
  logic        m_lock, m_terr;
  logic [15:0] m_w[NCH];   // last 16 bits seen per channel
  logic        m_cap_prev;
  logic [31:0] m_par;

  task automatic model_reset();
    m_mode = S_FREE; m_pos = 0; m_tmo = 0; m_lock = 0; m_terr = 0;
    m_cap_prev = 0; m_par = '0;
    for (int i = 0; i < NCH; i++) m_w[i] = '0;
    cq.delete(); sq.delete();
  endtask

  task automatic model_step(input logic [1:0] s, input logic a);
    int   e, nidle;
    logic hit, sup, was_search;
    e = ecnt + 1;
    if (m_cap_prev) begin
      nidle = 0;
      for (int i = 0; i < NCH; i++) if (m_par[i*16 +: 16] == IDLE) nidle++;
      sup = (idle_mode == 2'd0 && nidle > 0) || (idle_mode == 2'd1 && nidle == NCH);
      cq.push_back('{stamp: e, par: m_par, wr: !sup});
    end
    hit = (m_w[0] == SYNC);
    m_cap_prev = run && (m_pos == W - 1) && (m_mode != S_SEARCH);
    if (m_cap_prev) m_par = {m_w[1], m_w[0]};
    was_search = (m_mode == S_SEARCH);
    if (m_mode == S_SEARCH) begin
      if (hit) begin m_mode = S_LOCK; m_lock = 1; end
      else if (a) m_tmo = 0;
      else if (m_tmo == TMO - 1) begin m_terr = 1; m_mode = S_FREE; end
      else m_tmo++;
    end else if (a) begin
      m_mode = S_SEARCH; m_tmo = 0; m_lock = 0; m_terr = 0;
    end
    m_pos = (was_search && hit) ? 0 : (m_pos + 1) % W;
    for (int i = 0; i < NCH; i++) m_w[i] = {m_w[i][14:0], s[i]};
    sq.push_back('{stamp: e, lock: m_lock, terr: m_terr, match: (m_w[0] == SYNC)});
  endtask

  // ---------------- monitor ----------------
  initial begin
    int    n;
    cap_t  c;
    stat_t st;
    forever begin
      @(negedge clk160);
      if (!reset) begin
        n = ecnt;
        while (sq.size() > 0 && sq[0].stamp < n) void'(sq.pop_front());
        while (cq.size() > 0 && cq[0].stamp < n) void'(cq.pop_front());
        if (sq.size() > 0 && sq[0].stamp == n) begin
          st = sq.pop_front();
          chk("locked", 64'(locked), 64'(st.lock));
          chk("timeout_err", 64'(timeout_err), 64'(st.terr));
          chk("test_match", 64'(test[1]), 64'(st.match));
        end
        if (cq.size() > 0 && cq[0].stamp == n) begin
          c = cq.pop_front();
          chk("write", 64'(write), 64'(c.wr));
          chk("par", 64'(par), 64'(c.par));
        end else begin
          chk("spurious_write", 64'(write), 64'(0));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [1:0] s, input logic a);
    ser   = s;
    align = a;
    model_step(s, a);
    @(negedge clk160);
  endtask

  task automatic send(input logic [15:0] w0, input logic [15:0] w1);
    for (int b = 15; b >= 0; b--) tick({w1[b], w0[b]}, 1'b0);
  endtask

  task automatic to_boundary();
    while (m_pos != 0) tick(2'($urandom), 1'b0);
  endtask

  task automatic zero_ch0(input int n, input logic a_first);
    for (int k = 0; k < n; k++) tick({1'($urandom), 1'b0}, (k == 0) && a_first);
  endtask

  // Clear channel 0 history, request alignment, then present the sync word
  // after 'offset' filler bits.
  task automatic lock_seq(input int offset);
    zero_ch0(16, 1'b0);
    zero_ch0(1 + offset, 1'b1);
    send(SYNC, 16'($urandom));
  endtask

  function automatic logic [15:0] pick();
    return ($urandom_range(0, 2) == 0) ? IDLE : 16'($urandom);
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge clk160);
    #1 reset = 1'b0;
    run = 1'b1;
    idle_mode = 2'd0;

    // legacy free-running capture
    to_boundary();
    send(16'hA5C3, 16'h0F0F);
    send(16'($urandom), IDLE);
    // idle-mode sweep
    send(IDLE, 16'h1234);
    idle_mode = 2'd1;
    send(IDLE, 16'h1234);
    send(IDLE, IDLE);
    idle_mode = 2'd2;
    send(16'($urandom), 16'($urandom));
    send(IDLE, IDLE);
    send(IDLE, 16'h1234);
    idle_mode = 2'd0;

    // alignment at bit offset 5
    lock_seq(5);
    send(16'h1234, 16'($urandom));
    send(16'h5678, 16'($urandom));
    send(SYNC, 16'($urandom));

    // search timeout, free-run resumes, next align clears the error
    zero_ch0(16, 1'b0);
    zero_ch0(TMO + 6, 1'b1);
    repeat (40) tick(2'($urandom), 1'b0);
    lock_seq(2);
    send(16'hCAFE, 16'hBEEF);

    // realign with the stream phase moved by 3 bits
    lock_seq(3);
    send(16'h0123, 16'h4567);
    send(16'h89AB, 16'hCDEF);

    // run gating mid-word
    repeat (7) tick(2'($urandom), 1'b0);
    run = 1'b0;
    repeat (20) tick(2'($urandom), 1'b0);
    run = 1'b1;
    to_boundary();
    send(16'h1357, 16'h2468);

    // randomised words, modes and run toggles
    for (int k = 0; k < 30; k++) begin
      idle_mode = 2'($urandom);
      run = ($urandom_range(0, 7) != 0);
      send(pick(), pick());
    end
    run = 1'b1;

    // reset asserted during SEARCH
    zero_ch0(16, 1'b0);
    zero_ch0(10, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_par", 64'(par), 64'(0));
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_test", 64'(test), 64'(0));
    model_reset();
    @(negedge clk160);
    #1 reset = 1'b0;

    // legacy operation after reset
    idle_mode = 2'd0;
    to_boundary();
    send(16'hA5C3, 16'h0F0F);
    send(16'h5A5A, 16'h3C3C);

    // drain
    run = 1'b0;
    repeat (20) tick(2'b00, 1'b0);
    #1;
    chk("queues_drained", 64'(cq.size() + sq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
